booth_mult_arbiter: RTL and testbench

Round-robin arbiter and issue scheduler that shares one registered radix-4 Booth multiplier (`radix4BoothWithRegs`) between two requesters. Each requester presents signed 32-bit operands under a valid/ready handshake. The block issues at most one operation per cycle into the pipelined multiplier and tracks ownership of every in-flight operation with a tag pipeline. It returns each signed 64-bit product on a shared response bus labelled with the requester ID.

---
 rtl/booth_mult_arbiter_pkg.sv | 16 +
 rtl/mult_tag_pipe.sv | 32 +++
 rtl/radix4BoothWithRegs.sv | 54 +++++
 rtl/booth_mult_arbiter.sv | 112 +++++++++++
 tb/tb_booth_mult_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/booth_mult_arbiter_pkg.sv
// Shared types and widths for the two-requester Booth multiplier arbiter.
package booth_mult_arbiter_pkg;

   localparam int unsigned MULT_W = 32;
   localparam int unsigned PROD_W = 64;

   // Requester identifier: 0 or 1.
   typedef logic req_id_t;

   // Ownership tag carried alongside each in-flight multiply.
   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

endpackage

// File: rtl/mult_tag_pipe.sv
// Shift register of {valid, id} tags that tracks ownership of in-flight multiplies.
module mult_tag_pipe import booth_mult_arbiter_pkg::*; #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  tag_t tag_in,
   output tag_t tag_out,
   output logic any_valid
);

   tag_t stage_q [DEPTH];

   // Stage 0 loads every cycle; each later stage follows its predecessor.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_in;
         for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   // Any valid stage means work is still in flight.
   always_comb begin
      any_valid = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) any_valid = any_valid | stage_q[i].valid;
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/radix4BoothWithRegs.sv
// Registered radix-4 Booth multiplier: signed 32x32 -> 64, LATENCY register stages.
// The product of operands presented before edge N is on `product` after edge N+LATENCY-1,
// i.e. LATENCY cycles after the issue cycle.
module radix4BoothWithRegs #(
   parameter int unsigned LATENCY = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic signed [63:0] product
);

   // Sum of 16 radix-4 Booth partial products; top digit uses b[31] as the sign.
   function automatic logic signed [63:0] booth_mul(input logic signed [31:0] x,
                                                    input logic signed [31:0] y);
      logic [32:0]        yx;
      logic [2:0]         trip;
      logic signed [63:0] mcand;
      logic signed [63:0] pp;
      logic signed [63:0] acc;
      yx    = {y, 1'b0};
      mcand = {{32{x[31]}}, x};
      acc   = '0;
      for (int i = 0; i < 16; i++) begin
         trip = yx[2*i +: 3];
         case (trip)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand <<< 1;
            3'b100:         pp = -(mcand <<< 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
         endcase
         acc = acc + (pp <<< (2 * i));
      end
      return acc;
   endfunction

   logic signed [63:0] prod_q [LATENCY];

   // Product pipeline: stage 0 captures the fresh product, later stages delay it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < LATENCY; i++) prod_q[i] <= '0;
      end else if (en) begin
         prod_q[0] <= booth_mul(a, b);
         for (int unsigned i = 1; i < LATENCY; i++) prod_q[i] <= prod_q[i-1];
      end
   end

   assign product = prod_q[LATENCY-1];

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin issue of two requesters into one shared pipelined Booth multiplier,
// with a tag pipeline routing each product back to its owner.
module booth_mult_arbiter import booth_mult_arbiter_pkg::*; #(
   parameter int unsigned MULT_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [MULT_W-1:0] req0_a,
   input  logic [MULT_W-1:0] req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [MULT_W-1:0] req1_a,
   input  logic [MULT_W-1:0] req1_b,
   output logic              req1_ready,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [PROD_W-1:0] rsp_result,
   output logic              busy
);

   // Goes high on the first edge after reset release; keeps the async reset net
   // out of the grant datapath while forcing ready low during reset.
   logic              active_q;
   req_id_t           last_grant_q;
   logic [MULT_W-1:0] hold_a_q;
   logic [MULT_W-1:0] hold_b_q;

   logic              grant_valid;
   req_id_t           grant_id;
   logic [MULT_W-1:0] mult_a;
   logic [MULT_W-1:0] mult_b;
   logic [PROD_W-1:0] product;
   tag_t              tag_in;
   tag_t              tag_out;

   // Arbitration: a lone requester wins; on a tie the one not granted last wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (active_q) begin
         if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant_q;
         end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
      end
   end

   assign req0_ready = grant_valid && (grant_id == 1'b0);
   assign req1_ready = grant_valid && (grant_id == 1'b1);

   // Issue mux: granted operands, else hold the last issued pair.
   always_comb begin
      mult_a = hold_a_q;
      mult_b = hold_b_q;
      if (grant_valid) begin
         mult_a = grant_id ? req1_a : req0_a;
         mult_b = grant_id ? req1_b : req0_b;
      end
   end

   // Arbiter state: round-robin pointer and held operands update only on accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q     <= 1'b0;
         last_grant_q <= 1'b1;
         hold_a_q     <= '0;
         hold_b_q     <= '0;
      end else begin
         active_q <= 1'b1;
         if (grant_valid) begin
            last_grant_q <= grant_id;
            hold_a_q     <= mult_a;
            hold_b_q     <= mult_b;
         end
      end
   end

   assign tag_in = '{valid: grant_valid, id: grant_id};

   radix4BoothWithRegs #(
      .LATENCY (MULT_LATENCY)
   ) u_mult (
      .clk     (clk),
      .reset   (~reset),
      .en      (1'b1),
      .a       (mult_a),
      .b       (mult_b),
      .product (product)
   );

   mult_tag_pipe #(
      .DEPTH (MULT_LATENCY)
   ) u_tags (
      .clk       (clk),
      .reset     (reset),
      .tag_in    (tag_in),
      .tag_out   (tag_out),
      .any_valid (busy)
   );

   assign rsp_valid  = tag_out.valid;
   assign rsp_id     = tag_out.id;
   assign rsp_result = product;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter: single issues, ties, edge operands, reset flush.
module tb_booth_mult_arbiter;

   localparam int unsigned L = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        rsp_valid, rsp_id, busy;
   logic [63:0] rsp_result;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        id;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [7];

   localparam logic [63:0] EXP_TIE0 = -64'sd143362716;
   localparam logic [63:0] EXP_TIE1 = 64'd67081;

   booth_mult_arbiter #(
      .MULT_LATENCY (L)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One lone request from requester `id`, then walk it through the pipeline.
   task automatic run_single(input logic id, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input string name);
      @(negedge clk);
      req0_valid = (id == 1'b0);
      req1_valid = (id == 1'b1);
      req0_a = a; req0_b = b; req1_a = a; req1_b = b;
      #1;
      check({name, " ready0"}, 64'(req0_ready), 64'(id == 1'b0));
      check({name, " ready1"}, 64'(req1_ready), 64'(id == 1'b1));
      for (int unsigned c = 1; c < L; c++) begin
         @(negedge clk);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         #1;
         check({name, " early rsp_valid"}, 64'(rsp_valid), 64'd0);
         check({name, " busy"}, 64'(busy), 64'd1);
      end
      @(negedge clk);
      #1;
      check({name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
      check({name, " rsp_id"}, 64'(rsp_id), 64'(id));
      check({name, " rsp_result"}, rsp_result, exp);
      check({name, " busy at retire"}, 64'(busy), 64'd1);
      @(negedge clk);
      #1;
      check({name, " rsp_valid after"}, 64'(rsp_valid), 64'd0);
      check({name, " busy after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      vecs[0] = '{id: 1'b1, a: 32'h50647236, b: 32'hB887CAAF, exp: 64'hE98E647F4142AEEA};
      vecs[1] = '{id: 1'b0, a: 32'hB887CAAF, b: 32'h887CAAF3, exp: 64'h215D8B0A7A419A1D};
      vecs[2] = '{id: 1'b0, a: 32'd1, b: 32'd1348760118, exp: 64'd1348760118};
      vecs[3] = '{id: 1'b1, a: 32'hB887CAAF, b: 32'd0, exp: 64'd0};
      vecs[4] = '{id: 1'b0, a: 32'h80000000, b: 32'h80000000, exp: 64'h4000000000000000};
      vecs[5] = '{id: 1'b1, a: 32'hFFFFFFFF, b: 32'h80000000, exp: 64'h0000000080000000};
      vecs[6] = '{id: 1'b1, a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, exp: 64'h3FFFFFFF00000001};

      // Reset asserted with both requesters valid: nothing may be granted.
      reset = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'd5; req0_b = 32'd6; req1_a = 32'd7; req1_b = 32'd8;
      #12;
      check("reset ready0", 64'(req0_ready), 64'd0);
      check("reset ready1", 64'(req1_ready), 64'd0);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_id", 64'(rsp_id), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);

      run_single(1'b0, 32'd553524, 32'd840, 64'd464960160, "basic");

      for (int i = 0; i < 7; i++) begin
         run_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Tie with held operands: last grant was 1, so 0,1,0,1...
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd553524; req0_b = -32'sd259;
      req1_valid = 1'b1; req1_a = -32'sd259;  req1_b = -32'sd259;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         #1;
         if (k < 8) begin
            check($sformatf("tie ready0 c%0d", k), 64'(req0_ready), 64'(k % 2 == 0));
            check($sformatf("tie ready1 c%0d", k), 64'(req1_ready), 64'(k % 2 == 1));
         end
         if (k >= 2) begin
            check($sformatf("tie rsp_valid c%0d", k), 64'(rsp_valid), 64'd1);
            check($sformatf("tie rsp_id c%0d", k), 64'(rsp_id), 64'((k - 2) % 2));
            check($sformatf("tie rsp_result c%0d", k), rsp_result,
                  ((k - 2) % 2 == 0) ? EXP_TIE0 : EXP_TIE1);
         end else begin
            check($sformatf("tie rsp_valid c%0d", k), 64'(rsp_valid), 64'd0);
         end
         @(negedge clk);
      end
      #1;
      check("tie drained rsp_valid", 64'(rsp_valid), 64'd0);
      check("tie drained busy", 64'(busy), 64'd0);

      // Two accepts from requester 0, then reset while they are in flight.
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
      #1;
      check("flush accept1", 64'(req0_ready), 64'd1);
      @(negedge clk);
      req0_a = 32'd7; req0_b = 32'd11;
      #1;
      check("flush accept2", 64'(req0_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      req1_valid = 1'b1;
      #1;
      check("flush reset ready0", 64'(req0_ready), 64'd0);
      check("flush reset ready1", 64'(req1_ready), 64'd0);
      check("flush reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("flush reset busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("flush post rsp_valid c%0d", k), 64'(rsp_valid), 64'd0);
         check($sformatf("flush post busy c%0d", k), 64'(busy), 64'd0);
         @(negedge clk);
      end

      // First tie after reset goes to requester 0.
      req0_valid = 1'b1; req0_a = 32'd6;  req0_b = -32'sd7;
      req1_valid = 1'b1; req1_a = 32'd9;  req1_b = 32'd9;
      #1;
      check("post-reset tie ready0", 64'(req0_ready), 64'd1);
      check("post-reset tie ready1", 64'(req1_ready), 64'd0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      #1;
      check("post-reset rsp_valid", 64'(rsp_valid), 64'd1);
      check("post-reset rsp_id", 64'(rsp_id), 64'd0);
      check("post-reset rsp_result", rsp_result, -64'sd42);
      @(negedge clk);
      #1;
      check("post-reset idle", 64'(rsp_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
